pixel_frame_buffer: RTL and testbench

//  Parametrised read/write frame store for interleaved multi-channel pixel data (R,G,B,... per pixel).

---
 rtl/pixel_frame_buffer.sv | 162 ++++++++++++++++
 tb/tb_pixel_frame_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_buffer.sv
// rtl/pixel_frame_buffer.sv - interleaved multi-channel pixel frame store with write/read/clear sequencing
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   on_off              block enable; low aborts the current operation and returns to IDLE
//   start, rw, clear    command strobe sampled in IDLE; clear beats rw; rw=1 write, rw=0 read
//   pause               read stall request from downstream
//   in_valid, data_in   camera sample stream; in_ready high while writing
//   data_out, out_valid registered read stream; data_out is zero whenever out_valid is low
//   done                one-cycle pulse on normal completion of write, read or clear
//   busy                high in any state other than IDLE
//   addr                current sample address

module pixel_frame_buffer #(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int CH = 3,
    parameter int DW = 8,
    localparam int DEPTH = N * M * CH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          on_off,
    input  logic          start,
    input  logic          rw,
    input  logic          clear,
    input  logic          pause,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_CLEAR
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [0:DEPTH-1];

    logic wr_beat;
    logic clr_beat;
    logic at_last;

    // Write and clear are the only memory writers and are mutually exclusive
    // by state, so a read issue never shares a cycle with a memory write.
    assign wr_beat  = on_off && (state == S_WRITE) && in_valid;
    assign clr_beat = on_off && (state == S_CLEAR);
    assign at_last  = (addr == LAST_ADDR);

    // Status flags are pure decodes of the state register.
    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_WRITE);

    // Storage array carries no reset so contents survive aborts and resets.
    always_ff @(posedge clk) begin
        if (wr_beat || clr_beat) begin
            mem[addr] <= clr_beat ? '0 : data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Pulse-style outputs default low; only a read issue or a
            // completing operation raises them for exactly one cycle.
            done      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;

            if (!on_off) begin
                state <= S_IDLE;
                addr  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            addr <= '0;
                            if (clear) begin
                                state <= S_CLEAR;
                            end else if (rw) begin
                                state <= S_WRITE;
                            end else begin
                                state <= S_READ;
                            end
                        end
                    end

                    S_WRITE: begin
                        if (in_valid) begin
                            if (at_last) begin
                                state <= S_IDLE;
                                addr  <= '0;
                                done  <= 1'b1;
                            end else begin
                                addr <= addr + AW'(1);
                            end
                        end
                    end

                    S_READ: begin
                        if (pause) begin
                            state <= S_WAIT;
                        end else begin
                            data_out  <= mem[addr];
                            out_valid <= 1'b1;
                            // done lines up with the final word rather than
                            // trailing it, so the consumer sees both together.
                            if (at_last) begin
                                state <= S_IDLE;
                                addr  <= '0;
                                done  <= 1'b1;
                            end else begin
                                addr <= addr + AW'(1);
                            end
                        end
                    end

                    S_WAIT: begin
                        // addr is held here, so the resumed issue continues
                        // exactly where the stall interrupted it.
                        if (!pause) begin
                            state <= S_READ;
                        end
                    end

                    S_CLEAR: begin
                        if (at_last) begin
                            state <= S_IDLE;
                            addr  <= '0;
                            done  <= 1'b1;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        addr  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb/tb_pixel_frame_buffer.sv - directed self-checking bench for pixel_frame_buffer

module tb_pixel_frame_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       on_off;
    logic       start_a;
    logic       start_b;
    logic       rw;
    logic       clear;
    logic       pause;
    logic       in_valid;
    logic [7:0] data_in_a;
    logic [9:0] data_in_b;

    logic       in_ready_a, out_valid_a, done_a, busy_a;
    logic [7:0] data_out_a;
    logic [3:0] addr_a;
    logic       in_ready_b, out_valid_b, done_b, busy_b;
    logic [9:0] data_out_b;
    logic [3:0] addr_b;

    pixel_frame_buffer dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .on_off    (on_off),
        .start     (start_a),
        .rw        (rw),
        .clear     (clear),
        .pause     (pause),
        .in_valid  (in_valid),
        .data_in   (data_in_a),
        .in_ready  (in_ready_a),
        .data_out  (data_out_a),
        .out_valid (out_valid_a),
        .done      (done_a),
        .busy      (busy_a),
        .addr      (addr_a)
    );

    pixel_frame_buffer #(.N(4), .M(3), .CH(1), .DW(10)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .on_off    (on_off),
        .start     (start_b),
        .rw        (rw),
        .clear     (clear),
        .pause     (pause),
        .in_valid  (in_valid),
        .data_in   (data_in_b),
        .in_ready  (in_ready_b),
        .data_out  (data_out_b),
        .out_valid (out_valid_b),
        .done      (done_b),
        .busy      (busy_b),
        .addr      (addr_b)
    );

    int checks = 0;
    int errors = 0;

    bit         sel_b = 1'b0;
    logic       cur_in_ready, cur_out_valid, cur_done, cur_busy;
    logic [9:0] cur_data_out;
    logic [3:0] cur_addr;

    always_comb begin
        cur_in_ready  = sel_b ? in_ready_b  : in_ready_a;
        cur_out_valid = sel_b ? out_valid_b : out_valid_a;
        cur_done      = sel_b ? done_b      : done_a;
        cur_busy      = sel_b ? busy_b      : busy_a;
        cur_data_out  = sel_b ? data_out_b  : {2'b00, data_out_a};
        cur_addr      = sel_b ? addr_b      : addr_a;
    end

    // results of the last read_frame
    logic [9:0] rd_q[$];
    int         rd_done_cnt;
    bit         rd_done_last;
    int         rd_span;
    int         rd_zero_viol;

    // results of the last write_frame
    int         wr_accepted;
    int         wr_done_early;
    bit         wr_done_last;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit v);
        if (sel_b) start_b = v;
        else       start_a = v;
    endtask

    task automatic cmd(input bit c, input bit w);
        rw = w;
        clear = c;
        set_start(1'b1);
        step();
        set_start(1'b0);
        rw = 1'b0;
        clear = 1'b0;
    endtask

    task automatic write_frame(input logic [9:0] base, input int n, input bit gaps);
        int cyc = 0;
        bit xfer;
        wr_accepted = 0;
        wr_done_early = 0;
        wr_done_last = 1'b0;
        while (wr_accepted < n && cyc < 200) begin
            in_valid = !(gaps && (cyc % 3 == 2));
            data_in_b = 10'(base + 10'(wr_accepted));
            data_in_a = 8'(base + 10'(wr_accepted));
            xfer = in_valid && cur_in_ready;
            step();
            cyc++;
            if (xfer) wr_accepted++;
            if (cur_done) begin
                if (xfer && wr_accepted == n) wr_done_last = 1'b1;
                else wr_done_early++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic read_frame(input int pause_at, input int pause_len, input int start_at);
        int cyc = 0;
        int pcnt = 0;
        int first = -1;
        int last = -1;
        rd_q = {};
        rd_done_cnt = 0;
        rd_done_last = 1'b0;
        rd_zero_viol = 0;
        while (rd_q.size() < 12 && cyc < 200) begin
            if (pause_len > 0 && pcnt < pause_len && cur_busy && cur_addr == 4'(pause_at)) begin
                pause = 1'b1;
                pcnt++;
            end else begin
                pause = 1'b0;
            end
            if (cyc == start_at) begin
                rw = 1'b1;
                clear = 1'b1;
                set_start(1'b1);
            end else begin
                set_start(1'b0);
                rw = 1'b0;
                clear = 1'b0;
            end
            step();
            cyc++;
            if (cur_out_valid) begin
                rd_q.push_back(cur_data_out);
                if (first < 0) first = cyc;
                last = cyc;
            end else if (cur_data_out !== 10'd0) begin
                rd_zero_viol++;
            end
            if (cur_done) begin
                rd_done_cnt++;
                if (cur_out_valid && rd_q.size() == 12) rd_done_last = 1'b1;
            end
        end
        pause = 1'b0;
        set_start(1'b0);
        rw = 1'b0;
        clear = 1'b0;
        // one trailing cycle catches stray words or a second done pulse
        step();
        if (cur_out_valid) rd_q.push_back(cur_data_out);
        if (cur_done) rd_done_cnt++;
        rd_span = last - first + 1;
    endtask

    task automatic check_read(input string tag, input logic [9:0] exp[12], input int exp_span);
        checks++;
        if (rd_q.size() != 12) begin errors++; $display("FAIL %s word count: got %0d, expected 12", tag, rd_q.size()); end
        for (int i = 0; i < 12 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp[i]) begin errors++; $display("FAIL %s word %0d: got %0h, expected %0h", tag, i, rd_q[i], exp[i]); end
        end
        checks++;
        if (rd_span != exp_span) begin errors++; $display("FAIL %s valid span: got %0d, expected %0d", tag, rd_span, exp_span); end
        checks++;
        if (rd_done_cnt != 1) begin errors++; $display("FAIL %s done count: got %0d, expected 1", tag, rd_done_cnt); end
        checks++;
        if (rd_done_last !== 1'b1) begin errors++; $display("FAIL %s done with last word: got %0d, expected 1", tag, rd_done_last); end
        checks++;
        if (rd_zero_viol != 0) begin errors++; $display("FAIL %s data_out nonzero while invalid: got %0d, expected 0", tag, rd_zero_viol); end
        checks++;
        if (cur_busy !== 1'b0) begin errors++; $display("FAIL %s busy after read: got %0b, expected 0", tag, cur_busy); end
    endtask

    task automatic check_write(input string tag, input int n);
        checks++;
        if (wr_accepted != n) begin errors++; $display("FAIL %s beats accepted: got %0d, expected %0d", tag, wr_accepted, n); end
        checks++;
        if (wr_done_early != 0) begin errors++; $display("FAIL %s early done: got %0d, expected 0", tag, wr_done_early); end
        checks++;
        if (wr_done_last !== 1'b1) begin errors++; $display("FAIL %s done after last beat: got %0d, expected 1", tag, wr_done_last); end
        step();
        checks++;
        if (cur_done !== 1'b0 || cur_busy !== 1'b0) begin
            errors++; $display("FAIL %s done/busy after pulse: got %0b/%0b, expected 0/0", tag, cur_done, cur_busy);
        end
    endtask

    task automatic test_reset();
        sel_b = 1'b0;
        #1;
        checks++;
        if ({busy_a, in_ready_a, out_valid_a, done_a, addr_a, data_out_a} !== 16'h0 ||
            {busy_b, in_ready_b, out_valid_b, done_b, addr_b, data_out_b} !== 18'h0) begin
            errors++; $display("FAIL reset state: got a=%0h b=%0h, expected 0",
                {busy_a, in_ready_a, out_valid_a, done_a, addr_a, data_out_a},
                {busy_b, in_ready_b, out_valid_b, done_b, addr_b, data_out_b});
        end
        #3 rst_n = 1'b1;
        step();
        cmd(1'b0, 1'b1);
        write_frame(10'h055, 3, 1'b0);
        checks++;
        if (busy_a !== 1'b1 || in_ready_a !== 1'b1 || addr_a !== 4'd3) begin
            errors++; $display("FAIL mid-write status: got busy=%0b ready=%0b addr=%0d, expected 1 1 3", busy_a, in_ready_a, addr_a);
        end
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, in_ready_a, out_valid_a, done_a, addr_a, data_out_a} !== 16'h0) begin
            errors++; $display("FAIL async reset mid-write: got %0h, expected 0", {busy_a, in_ready_a, out_valid_a, done_a, addr_a, data_out_a});
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 4'd0) begin
            errors++; $display("FAIL after reset release: got busy=%0b done=%0b addr=%0d, expected 0 0 0", busy_a, done_a, addr_a);
        end
    endtask

    task automatic test_write_read();
        logic [9:0] exp[12];
        sel_b = 1'b0;
        for (int i = 0; i < 12; i++) exp[i] = 10'h010 + 10'(i);
        cmd(1'b0, 1'b1);
        write_frame(10'h010, 12, 1'b1);
        check_write("write_a", 12);
        cmd(1'b0, 1'b0);
        read_frame(-1, 0, -1);
        check_read("read_a", exp, 12);
    endtask

    task automatic test_pause();
        logic [9:0] exp[12];
        sel_b = 1'b0;
        for (int i = 0; i < 12; i++) exp[i] = 10'h010 + 10'(i);
        cmd(1'b0, 1'b0);
        read_frame(5, 3, -1);
        check_read("pause_read", exp, 16);
    endtask

    task automatic test_abort();
        logic [9:0] exp[12];
        sel_b = 1'b0;
        for (int i = 0; i < 6; i++)  exp[i] = 10'h0A0 + 10'(i);
        for (int i = 6; i < 12; i++) exp[i] = 10'h010 + 10'(i);
        cmd(1'b0, 1'b1);
        write_frame(10'h0A0, 6, 1'b0);
        checks++;
        if (wr_done_early != 0 || wr_done_last !== 1'b0 || wr_accepted != 6) begin
            errors++; $display("FAIL abort partial write: got acc=%0d early=%0d last=%0d, expected 6 0 0", wr_accepted, wr_done_early, wr_done_last);
        end
        checks++;
        if (addr_a !== 4'd6) begin errors++; $display("FAIL abort addr before off: got %0d, expected 6", addr_a); end
        on_off = 1'b0;
        step();
        checks++;
        if (busy_a !== 1'b0 || addr_a !== 4'd0 || done_a !== 1'b0) begin
            errors++; $display("FAIL abort on_off low: got busy=%0b addr=%0d done=%0b, expected 0 0 0", busy_a, addr_a, done_a);
        end
        on_off = 1'b1;
        step();
        checks++;
        if (done_a !== 1'b0) begin errors++; $display("FAIL abort late done: got %0b, expected 0", done_a); end
        cmd(1'b0, 1'b0);
        read_frame(-1, 0, -1);
        check_read("abort_read", exp, 12);
    endtask

    task automatic test_clear();
        logic [9:0] exp[12];
        int busy_cnt = 0;
        int cyc = 0;
        logic done_end = 1'b0;
        sel_b = 1'b0;
        for (int i = 0; i < 12; i++) exp[i] = 10'h000;
        cmd(1'b1, 1'b1);
        if (busy_a) busy_cnt++;
        checks++;
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL clear priority in_ready: got %0b, expected 0", in_ready_a); end
        while (busy_a && cyc < 50) begin
            step();
            cyc++;
            if (busy_a) busy_cnt++;
            else done_end = done_a;
        end
        checks++;
        if (busy_cnt != 12) begin errors++; $display("FAIL clear busy cycles: got %0d, expected 12", busy_cnt); end
        checks++;
        if (done_end !== 1'b1) begin errors++; $display("FAIL clear done: got %0b, expected 1", done_end); end
        cmd(1'b0, 1'b0);
        read_frame(-1, 0, -1);
        check_read("clear_read", exp, 12);
    endtask

    task automatic test_start_ignored();
        logic [9:0] exp[12];
        sel_b = 1'b0;
        for (int i = 0; i < 12; i++) exp[i] = 10'h030 + 10'(i);
        cmd(1'b0, 1'b1);
        write_frame(10'h030, 12, 1'b0);
        check_write("rewrite_a", 12);
        cmd(1'b0, 1'b0);
        read_frame(-1, 0, 3);
        check_read("start_ignored", exp, 12);
    endtask

    task automatic test_wide_geometry();
        logic [9:0] exp[12];
        sel_b = 1'b1;
        for (int i = 0; i < 12; i++) exp[i] = 10'h210 + 10'(i);
        cmd(1'b0, 1'b1);
        write_frame(10'h210, 12, 1'b1);
        check_write("write_b", 12);
        cmd(1'b0, 1'b0);
        read_frame(-1, 0, -1);
        check_read("read_b", exp, 12);
        sel_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        on_off = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        rw = 1'b0;
        clear = 1'b0;
        pause = 1'b0;
        in_valid = 1'b0;
        data_in_a = '0;
        data_in_b = '0;
        test_reset();
        test_write_read();
        test_pause();
        test_abort();
        test_clear();
        test_start_ignored();
        test_wide_geometry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
